// File: rtl/lc3_dmem_responder.sv
// LC-3 data-memory responder: one access at a time, WAIT_CYCLES wait states, DMem_ready pulse on completion.
// Latency WAIT_CYCLES+1 cycles from accept to ready; DMem_en is ignored while busy (requester holds off until DMem_ready).
module lc3_dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        DMem_en,
    input  logic        DMem_rd,
    input  logic [15:0] DMem_addr,
    input  logic [15:0] DMem_din,
    output logic [15:0] DMem_dout,
    output logic        DMem_ready,
    output logic        busy,
    output logic        addr_err,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int         DEPTH   = 1 << ADDR_W;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    logic [15:0] mem [DEPTH];

    state_t      state_q, state_d;
    logic        rd_q, rd_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] din_q, din_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [15:0] dout_q, dout_d;
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;
    logic        addr_err_q, addr_err_d;

    logic              cpl;
    logic              cpl_rd;
    logic [15:0]       cpl_addr;
    logic [15:0]       cpl_din;
    logic              cpl_oor;
    logic [ADDR_W-1:0] cpl_idx;
    logic              mem_we;

    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        addr_d   = addr_q;
        din_d    = din_q;
        wcnt_d   = wcnt_q;
        cpl      = 1'b0;
        cpl_rd   = rd_q;
        cpl_addr = addr_q;
        cpl_din  = din_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (DMem_en) begin
                    rd_d   = DMem_rd;
                    addr_d = DMem_addr;
                    din_d  = DMem_din;
                    wcnt_d = WAIT_LD;
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                    end else begin
                        // Zero wait states: the accept edge is also the completion edge.
                        state_d  = S_RESP;
                        cpl      = 1'b1;
                        cpl_rd   = DMem_rd;
                        cpl_addr = DMem_addr;
                        cpl_din  = DMem_din;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (wcnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    cpl     = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cpl_oor    = (cpl_addr >> ADDR_W) != 16'd0;
        cpl_idx    = cpl_addr[ADDR_W-1:0];
        mem_we     = cpl && !cpl_rd && !cpl_oor;
        dout_d     = dout_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        addr_err_d = addr_err_q | (cpl & cpl_oor);
        if (cpl && cpl_rd) begin
            dout_d = cpl_oor ? 16'h0000 : mem[cpl_idx];
            if (rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
        end
        if (cpl && !cpl_rd && wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rd_q       <= 1'b0;
            addr_q     <= 16'h0000;
            din_q      <= 16'h0000;
            wcnt_q     <= 4'd0;
            dout_q     <= 16'h0000;
            rd_count_q <= 16'h0000;
            wr_count_q <= 16'h0000;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            wcnt_q     <= wcnt_d;
            dout_q     <= dout_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Storage is deliberately left out of reset so contents survive a reset.
    always_ff @(posedge clock) begin
        if (mem_we) mem[cpl_idx] <= cpl_din;
    end

    assign DMem_dout  = dout_q;
    assign DMem_ready = (state_q == S_RESP);
    assign busy       = (state_q == S_WAIT);
    assign addr_err   = addr_err_q;
    assign rd_count   = rd_count_q;
    assign wr_count   = wr_count_q;
endmodule

// File: tb/tb_lc3_dmem_responder.sv
// Bench for lc3_dmem_responder: a zero-wait instance driven by directed and random traffic against
// an associative-array memory model, plus a three-wait-state instance for timing and reset-abort checks.
module tb_lc3_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        rst0, en0, rd0, rdy0, busy0, err0;
    logic [15:0] addr0, din0, dout0, rc0, wc0;
    logic        rst3, en3, rd3, rdy3, busy3, err3;
    logic [15:0] addr3, din3, dout3, rc3, wc3;

    lc3_dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
        .clock(clk), .reset(rst0), .DMem_en(en0), .DMem_rd(rd0), .DMem_addr(addr0),
        .DMem_din(din0), .DMem_dout(dout0), .DMem_ready(rdy0), .busy(busy0),
        .addr_err(err0), .rd_count(rc0), .wr_count(wc0));

    lc3_dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(3)) dut3 (
        .clock(clk), .reset(rst3), .DMem_en(en3), .DMem_rd(rd3), .DMem_addr(addr3),
        .DMem_din(din3), .DMem_dout(dout3), .DMem_ready(rdy3), .busy(busy3),
        .addr_err(err3), .rd_count(rc3), .wr_count(wc3));

    // Reference model for dut0: sparse memory of written words plus plain counters.
    logic [15:0] mmem [int];
    int          m_rd = 0;
    int          m_wr = 0;
    logic        m_err = 1'b0;
    logic [15:0] m_dout = 16'h0000;
    int          wq[$];

    // One zero-wait access on dut0; called at a negedge, returns at the next negedge with en0 low.
    task automatic acc0(input logic rd, input logic [15:0] addr, input logic [15:0] din);
        logic        oor;
        int          idx;
        logic [15:0] exp;
        logic        known;
        en0 = 1'b1; rd0 = rd; addr0 = addr; din0 = din;
        oor = (addr[15:8] != 8'h00);
        idx = int'(addr[7:0]);
        known = 1'b0;
        exp = 16'h0000;
        if (oor) m_err = 1'b1;
        if (rd) begin
            known = oor || mmem.exists(idx);
            if (!oor && known) exp = mmem[idx];
            if (known) m_dout = exp;
            if (m_rd < 65535) m_rd++;
        end else begin
            if (!oor) mmem[idx] = din;
            if (m_wr < 65535) m_wr++;
        end
        @(negedge clk);
        en0 = 1'b0;
        checks++;
        if (rdy0 !== 1'b1) begin errors++; $display("FAIL acc_ready addr=%h got=%b want=1", addr, rdy0); end
        if (known || !rd) begin
            checks++;
            if (dout0 !== m_dout) begin errors++; $display("FAIL acc_dout rd=%b addr=%h got=%h want=%h", rd, addr, dout0, m_dout); end
        end
        checks++;
        if (rc0 !== 16'(m_rd)) begin errors++; $display("FAIL rd_count got=%h want=%h", rc0, 16'(m_rd)); end
        checks++;
        if (wc0 !== 16'(m_wr)) begin errors++; $display("FAIL wr_count got=%h want=%h", wc0, 16'(m_wr)); end
        checks++;
        if (err0 !== m_err) begin errors++; $display("FAIL addr_err got=%b want=%b", err0, m_err); end
    endtask

    task automatic idle0(input int n);
        en0 = 1'b0;
        repeat (n) begin
            @(negedge clk);
            checks++;
            if (rdy0 !== 1'b0 || busy0 !== 1'b0) begin
                errors++; $display("FAIL idle0 ready=%b busy=%b want 0/0", rdy0, busy0);
            end
        end
    endtask

    // One access on dut3; returns the number of cycles from accept edge to the ready cycle (0 on timeout).
    task automatic acc3(input logic rd, input logic [15:0] addr, input logic [15:0] din, output int lat);
        en3 = 1'b1; rd3 = rd; addr3 = addr; din3 = din;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            en3 = 1'b0;
            if (rdy3 === 1'b1) begin lat = i; break; end
        end
        checks++;
        if (lat != 4) begin errors++; $display("FAIL acc3_latency addr=%h got=%0d want=4", addr, lat); end
        @(negedge clk);
        checks++;
        if (rdy3 !== 1'b0) begin errors++; $display("FAIL acc3_pulse got=%b want=0", rdy3); end
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst3 = 1'b1;
        en0 = 1'b0; rd0 = 1'b0; addr0 = 16'h0; din0 = 16'h0;
        en3 = 1'b0; rd3 = 1'b0; addr3 = 16'h0; din3 = 16'h0;
        repeat (2) @(negedge clk);
        checks++;
        if ({dout0, rdy0, busy0, err0, rc0, wc0} !== 52'h0) begin
            errors++; $display("FAIL reset_dut0 dout=%h rdy=%b busy=%b err=%b rc=%h wc=%h want all 0", dout0, rdy0, busy0, err0, rc0, wc0);
        end
        checks++;
        if ({dout3, rdy3, busy3, err3, rc3, wc3} !== 52'h0) begin
            errors++; $display("FAIL reset_dut3 dout=%h rdy=%b busy=%b err=%b rc=%h wc=%h want all 0", dout3, rdy3, busy3, err3, rc3, wc3);
        end
        rst0 = 1'b0; rst3 = 1'b0;
        idle0(1);
    endtask

    task automatic test_basic();
        acc0(1'b0, 16'h0012, 16'hBEEF);
        acc0(1'b1, 16'h0012, 16'h0000);
        checks++;
        if (dout0 !== 16'hBEEF || rc0 !== 16'd1 || wc0 !== 16'd1) begin
            errors++; $display("FAIL basic_rw dout=%h rc=%h wc=%h want BEEF/1/1", dout0, rc0, wc0);
        end
        idle0(2);
    endtask

    task automatic test_out_of_range();
        acc0(1'b0, 16'h0112, 16'h1234);
        acc0(1'b1, 16'h0012, 16'h0000);
        checks++;
        if (dout0 !== 16'hBEEF) begin errors++; $display("FAIL oor_alias got=%h want=BEEF", dout0); end
        acc0(1'b1, 16'h0112, 16'h0000);
        checks++;
        if (dout0 !== 16'h0000) begin errors++; $display("FAIL oor_read got=%h want=0000", dout0); end
        idle0(3);
        checks++;
        if (err0 !== 1'b1) begin errors++; $display("FAIL oor_sticky got=%b want=1", err0); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        for (int i = 0; i < 4; i++) begin
            d = 16'($urandom);
            acc0(1'b0, 16'h0040 + 16'(i), d);
            wq.push_back(64 + i);
        end
        for (int i = 0; i < 4; i++) acc0(1'b1, 16'h0040 + 16'(i), 16'h0000);
        idle0(1);
    endtask

    task automatic test_random();
        int          r;
        logic [15:0] a;
        wq.push_back(18);
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 7);
            if (r < 3) begin
                if (r == 0) a = {8'($urandom_range(1, 255)), 8'($urandom)};
                else begin a = {8'h00, 8'($urandom)}; wq.push_back(int'(a[7:0])); end
                acc0(1'b0, a, 16'($urandom));
            end else begin
                if (r == 7) a = {8'($urandom_range(1, 255)), 8'($urandom)};
                else a = 16'(wq[$urandom_range(0, wq.size() - 1)]);
                acc0(1'b1, a, 16'($urandom));
            end
            if ($urandom_range(0, 3) == 0) idle0($urandom_range(1, 3));
        end
    endtask

    task automatic test_saturate();
        force dut0.rd_count_q = 16'hFFFE;
        #1;
        release dut0.rd_count_q;
        m_rd = 65534;
        repeat (3) acc0(1'b1, 16'h0012, 16'h0000);
        checks++;
        if (rc0 !== 16'hFFFF) begin errors++; $display("FAIL saturate got=%h want=FFFF", rc0); end
        idle0(1);
    endtask

    task automatic test_wait3();
        int lat;
        acc3(1'b0, 16'h0020, 16'h1357, lat);
        en3 = 1'b1; rd3 = 1'b1; addr3 = 16'h0020; din3 = 16'h0000;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy3 !== 1'b1 || rdy3 !== 1'b0) begin
                errors++; $display("FAIL wait3_busy cycle=%0d busy=%b rdy=%b want 1/0", i, busy3, rdy3);
            end
            // Stray requests during the wait must be ignored.
            en3 = (i != 1); rd3 = 1'b0; addr3 = 16'h0020; din3 = 16'hFFFF;
            @(negedge clk);
        end
        en3 = 1'b0;
        checks++;
        if (rdy3 !== 1'b1 || busy3 !== 1'b0 || dout3 !== 16'h1357) begin
            errors++; $display("FAIL wait3_resp rdy=%b busy=%b dout=%h want 1/0/1357", rdy3, busy3, dout3);
        end
        @(negedge clk);
        checks++;
        if (rdy3 !== 1'b0) begin errors++; $display("FAIL wait3_pulse got=%b want=0", rdy3); end
        acc3(1'b1, 16'h0020, 16'h0000, lat);
        checks++;
        if (dout3 !== 16'h1357 || rc3 !== 16'd2 || wc3 !== 16'd1) begin
            errors++; $display("FAIL wait3_ignored dout=%h rc=%h wc=%h want 1357/2/1", dout3, rc3, wc3);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        acc3(1'b0, 16'h0005, 16'h5555, lat);
        en3 = 1'b1; rd3 = 1'b0; addr3 = 16'h0005; din3 = 16'hAAAA;
        @(negedge clk);
        en3 = 1'b0;
        checks++;
        if (busy3 !== 1'b1) begin errors++; $display("FAIL rstmid_busy got=%b want=1", busy3); end
        rst3 = 1'b1;
        #1;
        checks++;
        if ({dout3, rdy3, busy3, err3, rc3, wc3} !== 52'h0) begin
            errors++; $display("FAIL rstmid_outputs dout=%h rdy=%b busy=%b err=%b rc=%h wc=%h want all 0", dout3, rdy3, busy3, err3, rc3, wc3);
        end
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (rdy3 !== 1'b0) begin errors++; $display("FAIL rstmid_noready got=%b want=0", rdy3); end
        end
        rst3 = 1'b0;
        @(negedge clk);
        acc3(1'b1, 16'h0005, 16'h0000, lat);
        checks++;
        if (dout3 !== 16'h5555 || rc3 !== 16'd1 || wc3 !== 16'd0) begin
            errors++; $display("FAIL rstmid_mem dout=%h rc=%h wc=%h want 5555/1/0", dout3, rc3, wc3);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_out_of_range();
        test_back_to_back();
        test_random();
        test_saturate();
        test_wait3();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
